ioctl_router: RTL and testbench
===============================

IOCTL_ROUTER -- requirements
Module: ioctl_router

Interface
REQ-001 Parameter NUM_REGIONS, default 4: number of ROM target regions (1..8).
REQ-002 Parameter ADDR_W, default 20: width of region-relative byte address.
REQ-003 Parameter REGION_BASE, default {27'h30000,27'h20000,27'h10000,27'h0}: packed NUM_REGIONS x 27-bit start byte addresses, ascending with k.
REQ-004 Parameter REGION_END, default 27'h40000: exclusive end address of the last region.
REQ-005 Parameter ROM_INDEX, default 0; DSW_INDEX, default 254: ioctl_index values for ROM and DIP-switch downloads.
REQ-006 Parameter DSW_BYTES, default 8: captured DIP bytes (1..8); DSW_DEFAULT, default all-ones: reset value.
REQ-007 clk_sys  in  1  system clock; all logic on rising edge.
REQ-008 reset_n  in  1  asynchronous, active-low reset.
REQ-009 ioctl_download  in  1  download active.
REQ-010 ioctl_index  in  8  download target index.
REQ-011 ioctl_addr  in  27  byte address of current word (even).
REQ-012 ioctl_dout  in  16  word data, low byte at ioctl_addr.
REQ-013 ioctl_wr  in  1  single-cycle word strobe.
REQ-014 ioctl_wait  out  1  host stall request.
REQ-015 rom_wr  out  NUM_REGIONS  one-hot byte write strobe per region.
REQ-016 rom_addr  out  ADDR_W  region-relative byte address.
REQ-017 rom_data  out  8  byte data.
REQ-018 dsw  out  8*DSW_BYTES  captured DIP bytes, byte n at [8n+7:8n].
REQ-019 load_done  out  1  one-cycle pulse at end of ROM download.
REQ-020 err_overrun  out  1  sticky: strobe arrived while busy.

Function
REQ-021 FSM states IDLE, LO, HI; IDLE on reset.
REQ-022 IDLE, ioctl_wr with ioctl_download and ioctl_index==ROM_INDEX and address inside a region: latch word, address, region; go LO; ioctl_wait high from next cycle.
REQ-023 Region k selected when REGION_BASE[k] <= ioctl_addr < next base (REGION_END for last); lowest k wins on overlap.
REQ-024 Address outside every region: word dropped, no rom_wr, no wait, FSM stays IDLE.
REQ-025 LO: rom_wr[k]=1, rom_addr=(addr-REGION_BASE[k])[ADDR_W-1:0], rom_data=low byte; go HI.
REQ-026 HI: rom_wr[k]=1, rom_addr=previous+1, rom_data=high byte; go IDLE; ioctl_wait low in the IDLE cycle after HI.
REQ-027 Latency: strobe at cycle N -> low byte at N+1, high byte at N+2; next word accepted from N+3.
REQ-028 ioctl_wr while in LO or HI: ignored, err_overrun set until reset.
REQ-029 rom_wr, rom_addr, rom_data registered; rom_wr zero outside LO/HI.
REQ-030 DSW: ioctl_wr with ioctl_index==DSW_INDEX and ioctl_addr<DSW_BYTES stores ioctl_dout[7:0] into byte ioctl_addr next cycle, regardless of FSM state; no wait; addresses >=DSW_BYTES ignored.
REQ-031 load_done pulses one cycle after ioctl_download falls for a ROM_INDEX download, delayed until FSM is IDLE if a word is in flight.
REQ-032 ioctl_download falling during LO/HI: pending byte writes still complete.

Reset
REQ-033 reset_n low: FSM IDLE, ioctl_wait=0, rom_wr=0, rom_addr=0, rom_data=0, load_done=0, err_overrun=0, dsw=DSW_DEFAULT, checksums 0; in-flight word discarded.

Configuration
REQ-034 With IOCTL_ROUTER_CHECKSUM_EN defined: extra output checksum, 8*NUM_REGIONS wide, byte k = mod-256 sum of all bytes written to region k, cleared on rising ioctl_download edge for ROM_INDEX.
REQ-035 Without IOCTL_ROUTER_CHECKSUM_EN: no checksum port, no summing logic.

Structure
REQ-036 Shared package ioctl_router_pkg holds FSM state enum, MAX_REGIONS=8, IOCTL_ADDR_W=27, and DSW_INDEX default.
REQ-037 One sub-module ioctl_region_decode: combinational address-to-one-hot region and offset decode.

Verification
REQ-038 ROM word addr 0x10004 data 0xBEEF -> rom_wr[1] at N+1 addr 0x4 data 0xEF, at N+2 addr 0x5 data 0xBE; ioctl_wait high N+1..N+2.
REQ-039 Word addr 0x50000 -> no rom_wr, ioctl_wait stays 0.
REQ-040 Second ioctl_wr at N+1 -> ignored, err_overrun=1 until reset.
REQ-041 DSW_INDEX writes addr 0 data 0x00A5, addr 9 -> dsw[7:0]=0xA5, other bytes 0xFF.
REQ-042 ioctl_download falls at N+1 of a word -> both bytes written, load_done pulses at N+3.
REQ-043 reset_n low at LO -> all outputs reset values asynchronously; HI byte never written.

Source files
------------

// File: rtl/ioctl_router_pkg.sv
// Shared types and constants for the ioctl download router.
package ioctl_router_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2
  } rtr_state_t;

  localparam int         MAX_REGIONS       = 8;
  localparam int         IOCTL_ADDR_W      = 27;
  localparam logic [7:0] DSW_INDEX_DEFAULT = 8'd254;

endpackage

// File: rtl/ioctl_region_decode.sv
// Combinational decode of a download byte address into a one-hot ROM region
// and the region-relative offset; the lowest matching region wins.
module ioctl_region_decode
  import ioctl_router_pkg::*;
#(
  parameter int                                  NUM_REGIONS = 4,
  parameter int                                  ADDR_W      = 20,
  parameter logic [NUM_REGIONS*IOCTL_ADDR_W-1:0] REGION_BASE =
    {27'h30000, 27'h20000, 27'h10000, 27'h0},
  parameter logic [IOCTL_ADDR_W-1:0]             REGION_END  = 27'h40000
) (
  input  logic [IOCTL_ADDR_W-1:0] addr,
  output logic                    hit,
  output logic [NUM_REGIONS-1:0]  region,
  output logic [ADDR_W-1:0]       offset
);

  logic [NUM_REGIONS-1:0]             in_rng;
  logic [NUM_REGIONS-1:0][ADDR_W-1:0] off_k;

  for (genvar k = 0; k < NUM_REGIONS; k++) begin : g_rng
    localparam logic [IOCTL_ADDR_W-1:0] LO =
      REGION_BASE[k*IOCTL_ADDR_W +: IOCTL_ADDR_W];
    // The modulo keeps the unused branch's select in range for the last region.
    localparam logic [IOCTL_ADDR_W-1:0] HI = (k == NUM_REGIONS-1) ? REGION_END :
      REGION_BASE[((k+1) % NUM_REGIONS)*IOCTL_ADDR_W +: IOCTL_ADDR_W];
    logic ge_lo;

    if (LO == '0) begin : g_zero
      assign ge_lo = 1'b1;
    end else begin : g_cmp
      assign ge_lo = (addr >= LO);
    end

    assign in_rng[k] = ge_lo && (addr < HI);
    assign off_k[k]  = ADDR_W'(addr - LO);
  end

  always_comb begin
    hit    = 1'b0;
    region = '0;
    offset = '0;
    for (int k = NUM_REGIONS-1; k >= 0; k--) begin
      if (in_rng[k]) begin
        hit       = 1'b1;
        region    = '0;
        region[k] = 1'b1;
        offset    = off_k[k];
      end
    end
  end

endmodule

// File: rtl/ioctl_router.sv
// Routes 16-bit ioctl download words into per-region byte writes and captures
// DIP-switch bytes. Optional per-region checksums: IOCTL_ROUTER_CHECKSUM_EN.
module ioctl_router
  import ioctl_router_pkg::*;
#(
  parameter int                                  NUM_REGIONS = 4,
  parameter int                                  ADDR_W      = 20,
  parameter logic [NUM_REGIONS*IOCTL_ADDR_W-1:0] REGION_BASE =
    {27'h30000, 27'h20000, 27'h10000, 27'h0},
  parameter logic [IOCTL_ADDR_W-1:0]             REGION_END  = 27'h40000,
  parameter logic [7:0]                          ROM_INDEX   = 8'd0,
  parameter logic [7:0]                          DSW_INDEX   = DSW_INDEX_DEFAULT,
  parameter int                                  DSW_BYTES   = 8,
  parameter logic [8*DSW_BYTES-1:0]              DSW_DEFAULT = '1
) (
  input  logic                      clk_sys,
  input  logic                      reset_n,
  input  logic                      ioctl_download,
  input  logic [7:0]                ioctl_index,
  input  logic [IOCTL_ADDR_W-1:0]   ioctl_addr,
  input  logic [15:0]               ioctl_dout,
  input  logic                      ioctl_wr,
  output logic                      ioctl_wait,
  output logic [NUM_REGIONS-1:0]    rom_wr,
  output logic [ADDR_W-1:0]         rom_addr,
  output logic [7:0]                rom_data,
  output logic [8*DSW_BYTES-1:0]    dsw,
  output logic                      load_done,
  output logic                      err_overrun
`ifdef IOCTL_ROUTER_CHECKSUM_EN
  ,
  output logic [8*NUM_REGIONS-1:0]  checksum
`endif
);

  rtr_state_t             state_q, state_d;
  logic                   dec_hit;
  logic [NUM_REGIONS-1:0] dec_region;
  logic [ADDR_W-1:0]      dec_offset;
  logic [7:0]             hi_p0;
  logic                   rom_strobe, dsw_strobe, accept;
  logic                   dl_q, rom_dl_q, done_pend_q;
  logic                   dl_rise, dl_fall, fall_rom, done_now;

  ioctl_region_decode #(
    .NUM_REGIONS (NUM_REGIONS),
    .ADDR_W      (ADDR_W),
    .REGION_BASE (REGION_BASE),
    .REGION_END  (REGION_END)
  ) u_decode (
    .addr   (ioctl_addr),
    .hit    (dec_hit),
    .region (dec_region),
    .offset (dec_offset)
  );

  assign rom_strobe = ioctl_wr && ioctl_download && (ioctl_index == ROM_INDEX);
  assign dsw_strobe = ioctl_wr && (ioctl_index == DSW_INDEX);
  assign accept     = rom_strobe && dec_hit && (state_q == ST_IDLE);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_LO;
      ST_LO:   state_d = ST_HI;
      ST_HI:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ioctl_wait = (state_q != ST_IDLE);
  end

  // p0: accepted word latched; low byte presented during LO, high byte during HI
  always_ff @(posedge clk_sys) begin
    if (accept) hi_p0 <= ioctl_dout[15:8];
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rom_wr   <= '0;
      rom_addr <= '0;
      rom_data <= '0;
    end else if (accept) begin
      rom_wr   <= dec_region;
      rom_addr <= dec_offset;
      rom_data <= ioctl_dout[7:0];
    end else if (state_q == ST_LO) begin
      rom_addr <= rom_addr + 1'b1;
      rom_data <= hi_p0;
    end else begin
      rom_wr   <= '0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)                              err_overrun <= 1'b0;
    else if (rom_strobe && state_q != ST_IDLE) err_overrun <= 1'b1;
  end

  for (genvar n = 0; n < DSW_BYTES; n++) begin : g_dsw
    logic [7:0] byte_q;
    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n)
        byte_q <= DSW_DEFAULT[8*n +: 8];
      else if (dsw_strobe && ioctl_addr == IOCTL_ADDR_W'(n))
        byte_q <= ioctl_dout[7:0];
    end
    assign dsw[8*n +: 8] = byte_q;
  end

  assign dl_rise  = ioctl_download && !dl_q;
  assign dl_fall  = !ioctl_download && dl_q;
  assign fall_rom = dl_fall && rom_dl_q;
  // A fall seen while a word is in flight is held until the FSM returns to IDLE.
  assign done_now = (fall_rom || done_pend_q) && (state_d == ST_IDLE);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dl_q        <= 1'b0;
      rom_dl_q    <= 1'b0;
      done_pend_q <= 1'b0;
      load_done   <= 1'b0;
    end else begin
      dl_q      <= ioctl_download;
      load_done <= done_now;
      if (dl_rise)      rom_dl_q <= (ioctl_index == ROM_INDEX);
      else if (dl_fall) rom_dl_q <= 1'b0;
      if (done_now)      done_pend_q <= 1'b0;
      else if (fall_rom) done_pend_q <= 1'b1;
    end
  end

`ifdef IOCTL_ROUTER_CHECKSUM_EN
  for (genvar k = 0; k < NUM_REGIONS; k++) begin : g_sum
    logic [7:0] sum_q;
    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n)                                  sum_q <= '0;
      else if (dl_rise && ioctl_index == ROM_INDEX)  sum_q <= '0;
      else if (rom_wr[k])                            sum_q <= sum_q + rom_data;
    end
    assign checksum[8*k +: 8] = sum_q;
  end
`endif

endmodule

// File: tb/tb_ioctl_router.sv
// Directed bench for ioctl_router: ROM word routing, region bounds, overrun,
// DIP capture, load_done timing and asynchronous reset.
module tb_ioctl_router;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic [26:0] ioctl_addr;
  logic [15:0] ioctl_dout;
  logic        ioctl_wr;
  logic        ioctl_wait;
  logic [3:0]  rom_wr;
  logic [19:0] rom_addr;
  logic [7:0]  rom_data;
  logic [63:0] dsw;
  logic        load_done;
  logic        err_overrun;
`ifdef IOCTL_ROUTER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk_sys = ~clk_sys;

  ioctl_router dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wr       (ioctl_wr),
    .ioctl_wait     (ioctl_wait),
    .rom_wr         (rom_wr),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .dsw            (dsw),
    .load_done      (load_done),
    .err_overrun    (err_overrun)
`ifdef IOCTL_ROUTER_CHECKSUM_EN
    ,
    .checksum       (checksum)
`endif
  );

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // One-cycle strobe; returns one cycle after the strobe cycle (N+1).
  task automatic drive_word(input logic [26:0] a, input logic [15:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'd0;
    ioctl_addr = '0; ioctl_dout = '0; ioctl_wr = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;
    total++; if (ioctl_wait !== 1'b0) begin bad++; $display("FAIL rst_wait got=%h exp=0", ioctl_wait); end
    total++; if (rom_wr !== 4'h0) begin bad++; $display("FAIL rst_wr got=%h exp=0", rom_wr); end
    total++; if (rom_addr !== 20'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", rom_addr); end
    total++; if (rom_data !== 8'h0) begin bad++; $display("FAIL rst_data got=%h exp=0", rom_data); end
    total++; if (load_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%h exp=0", load_done); end
    total++; if (err_overrun !== 1'b0) begin bad++; $display("FAIL rst_err got=%h exp=0", err_overrun); end
    total++; if (dsw !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL rst_dsw got=%h exp=ffffffffffffffff", dsw); end
    @(negedge clk_sys);
    reset_n = 1'b1;
  endtask

  task automatic test_rom_word();
    ioctl_index = 8'd0; ioctl_download = 1'b1;
    tick();
    drive_word(27'h10004, 16'hBEEF);
    total++; if (rom_wr !== 4'b0010) begin bad++; $display("FAIL word_lo_wr got=%h exp=2", rom_wr); end
    total++; if (rom_addr !== 20'h4) begin bad++; $display("FAIL word_lo_addr got=%h exp=4", rom_addr); end
    total++; if (rom_data !== 8'hEF) begin bad++; $display("FAIL word_lo_data got=%h exp=ef", rom_data); end
    total++; if (ioctl_wait !== 1'b1) begin bad++; $display("FAIL word_lo_wait got=%h exp=1", ioctl_wait); end
    tick();
    total++; if (rom_wr !== 4'b0010) begin bad++; $display("FAIL word_hi_wr got=%h exp=2", rom_wr); end
    total++; if (rom_addr !== 20'h5) begin bad++; $display("FAIL word_hi_addr got=%h exp=5", rom_addr); end
    total++; if (rom_data !== 8'hBE) begin bad++; $display("FAIL word_hi_data got=%h exp=be", rom_data); end
    total++; if (ioctl_wait !== 1'b1) begin bad++; $display("FAIL word_hi_wait got=%h exp=1", ioctl_wait); end
    tick();
    total++; if (rom_wr !== 4'b0000) begin bad++; $display("FAIL word_idle_wr got=%h exp=0", rom_wr); end
    total++; if (ioctl_wait !== 1'b0) begin bad++; $display("FAIL word_idle_wait got=%h exp=0", ioctl_wait); end
    drive_word(27'h3FFFE, 16'h1357);
    total++; if (rom_wr !== 4'b1000) begin bad++; $display("FAIL top_lo_wr got=%h exp=8", rom_wr); end
    total++; if (rom_addr !== 20'hFFFE) begin bad++; $display("FAIL top_lo_addr got=%h exp=fffe", rom_addr); end
    total++; if (rom_data !== 8'h57) begin bad++; $display("FAIL top_lo_data got=%h exp=57", rom_data); end
    tick();
    total++; if (rom_addr !== 20'hFFFF) begin bad++; $display("FAIL top_hi_addr got=%h exp=ffff", rom_addr); end
    total++; if (rom_data !== 8'h13) begin bad++; $display("FAIL top_hi_data got=%h exp=13", rom_data); end
    tick();
    drive_word(27'h0, 16'h2468);
    total++; if (rom_wr !== 4'b0001) begin bad++; $display("FAIL r0_wr got=%h exp=1", rom_wr); end
    total++; if (rom_addr !== 20'h0) begin bad++; $display("FAIL r0_addr got=%h exp=0", rom_addr); end
    total++; if (rom_data !== 8'h68) begin bad++; $display("FAIL r0_data got=%h exp=68", rom_data); end
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    drive_word(27'h20000, 16'h0102);
    total++; if (rom_wr !== 4'b0100) begin bad++; $display("FAIL b2b_a_wr got=%h exp=4", rom_wr); end
    total++; if (rom_data !== 8'h02) begin bad++; $display("FAIL b2b_a_data got=%h exp=02", rom_data); end
    tick();
    tick();
    total++; if (ioctl_wait !== 1'b0) begin bad++; $display("FAIL b2b_wait got=%h exp=0", ioctl_wait); end
    drive_word(27'h10100, 16'hCAFE);
    total++; if (rom_wr !== 4'b0010) begin bad++; $display("FAIL b2b_b_wr got=%h exp=2", rom_wr); end
    total++; if (rom_addr !== 20'h100) begin bad++; $display("FAIL b2b_b_addr got=%h exp=100", rom_addr); end
    total++; if (rom_data !== 8'hFE) begin bad++; $display("FAIL b2b_b_data got=%h exp=fe", rom_data); end
    total++; if (err_overrun !== 1'b0) begin bad++; $display("FAIL b2b_err got=%h exp=0", err_overrun); end
    tick();
    total++; if (rom_addr !== 20'h101) begin bad++; $display("FAIL b2b_b_addr2 got=%h exp=101", rom_addr); end
    total++; if (rom_data !== 8'hCA) begin bad++; $display("FAIL b2b_b_data2 got=%h exp=ca", rom_data); end
    tick();
  endtask

  task automatic test_out_of_range();
    drive_word(27'h50000, 16'h9999);
    total++; if (rom_wr !== 4'b0000) begin bad++; $display("FAIL oor_wr got=%h exp=0", rom_wr); end
    total++; if (ioctl_wait !== 1'b0) begin bad++; $display("FAIL oor_wait got=%h exp=0", ioctl_wait); end
    tick();
    total++; if (rom_wr !== 4'b0000) begin bad++; $display("FAIL oor_wr2 got=%h exp=0", rom_wr); end
    drive_word(27'h40000, 16'h7777);
    total++; if (rom_wr !== 4'b0000) begin bad++; $display("FAIL end_wr got=%h exp=0", rom_wr); end
    total++; if (ioctl_wait !== 1'b0) begin bad++; $display("FAIL end_wait got=%h exp=0", ioctl_wait); end
    tick();
  endtask

  task automatic test_load_done();
    ioctl_download = 1'b0;
    tick();
    total++; if (load_done !== 1'b1) begin bad++; $display("FAIL done_pulse got=%h exp=1", load_done); end
    tick();
    total++; if (load_done !== 1'b0) begin bad++; $display("FAIL done_end got=%h exp=0", load_done); end
  endtask

  task automatic test_fall_midword();
    ioctl_download = 1'b1;
    tick();
    drive_word(27'h20010, 16'h1234);
    ioctl_download = 1'b0;
    total++; if (rom_wr !== 4'b0100) begin bad++; $display("FAIL fall_lo_wr got=%h exp=4", rom_wr); end
    total++; if (rom_data !== 8'h34) begin bad++; $display("FAIL fall_lo_data got=%h exp=34", rom_data); end
    total++; if (load_done !== 1'b0) begin bad++; $display("FAIL fall_n1_done got=%h exp=0", load_done); end
    tick();
    total++; if (rom_wr !== 4'b0100) begin bad++; $display("FAIL fall_hi_wr got=%h exp=4", rom_wr); end
    total++; if (rom_addr !== 20'h11) begin bad++; $display("FAIL fall_hi_addr got=%h exp=11", rom_addr); end
    total++; if (rom_data !== 8'h12) begin bad++; $display("FAIL fall_hi_data got=%h exp=12", rom_data); end
    total++; if (load_done !== 1'b0) begin bad++; $display("FAIL fall_n2_done got=%h exp=0", load_done); end
    tick();
    total++; if (load_done !== 1'b1) begin bad++; $display("FAIL fall_n3_done got=%h exp=1", load_done); end
    total++; if (rom_wr !== 4'b0000) begin bad++; $display("FAIL fall_n3_wr got=%h exp=0", rom_wr); end
    tick();
    total++; if (load_done !== 1'b0) begin bad++; $display("FAIL fall_n4_done got=%h exp=0", load_done); end
  endtask

  task automatic test_overrun();
    ioctl_download = 1'b1;
    tick();
    ioctl_addr = 27'h2; ioctl_dout = 16'h5566; ioctl_wr = 1'b1;
    tick();
    ioctl_addr = 27'h10; ioctl_dout = 16'h7788;
    total++; if (rom_wr !== 4'b0001) begin bad++; $display("FAIL ovr_lo_wr got=%h exp=1", rom_wr); end
    total++; if (rom_data !== 8'h66) begin bad++; $display("FAIL ovr_lo_data got=%h exp=66", rom_data); end
    total++; if (err_overrun !== 1'b0) begin bad++; $display("FAIL ovr_early got=%h exp=0", err_overrun); end
    tick();
    ioctl_wr = 1'b0;
    total++; if (rom_addr !== 20'h3) begin bad++; $display("FAIL ovr_hi_addr got=%h exp=3", rom_addr); end
    total++; if (rom_data !== 8'h55) begin bad++; $display("FAIL ovr_hi_data got=%h exp=55", rom_data); end
    total++; if (err_overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got=%h exp=1", err_overrun); end
    tick();
    total++; if (rom_wr !== 4'b0000) begin bad++; $display("FAIL ovr_idle_wr got=%h exp=0", rom_wr); end
    tick();
    total++; if (rom_wr !== 4'b0000) begin bad++; $display("FAIL ovr_drop_wr got=%h exp=0", rom_wr); end
    total++; if (err_overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%h exp=1", err_overrun); end
    ioctl_download = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_dsw();
    ioctl_index = 8'd254; ioctl_download = 1'b1;
    tick();
    drive_word(27'h0, 16'h00A5);
    drive_word(27'h8, 16'h0011);
    drive_word(27'h9, 16'h0022);
    total++; if (dsw !== 64'hFFFF_FFFF_FFFF_FFA5) begin bad++; $display("FAIL dsw_b0 got=%h exp=ffffffffffffffa5", dsw); end
    total++; if (rom_wr !== 4'b0000) begin bad++; $display("FAIL dsw_romwr got=%h exp=0", rom_wr); end
    total++; if (ioctl_wait !== 1'b0) begin bad++; $display("FAIL dsw_wait got=%h exp=0", ioctl_wait); end
    drive_word(27'h7, 16'h003C);
    total++; if (dsw !== 64'h3CFF_FFFF_FFFF_FFA5) begin bad++; $display("FAIL dsw_b7 got=%h exp=3cffffffffffffa5", dsw); end
    ioctl_download = 1'b0;
    tick();
    total++; if (load_done !== 1'b0) begin bad++; $display("FAIL dsw_done got=%h exp=0", load_done); end
    tick();
  endtask

  task automatic test_reset_midword();
    ioctl_index = 8'd0; ioctl_download = 1'b1;
    tick();
    drive_word(27'h10000, 16'hABCD);
    total++; if (rom_data !== 8'hCD) begin bad++; $display("FAIL arst_lo_data got=%h exp=cd", rom_data); end
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (rom_wr !== 4'h0) begin bad++; $display("FAIL arst_wr got=%h exp=0", rom_wr); end
    total++; if (rom_addr !== 20'h0) begin bad++; $display("FAIL arst_addr got=%h exp=0", rom_addr); end
    total++; if (rom_data !== 8'h0) begin bad++; $display("FAIL arst_data got=%h exp=0", rom_data); end
    total++; if (ioctl_wait !== 1'b0) begin bad++; $display("FAIL arst_wait got=%h exp=0", ioctl_wait); end
    total++; if (err_overrun !== 1'b0) begin bad++; $display("FAIL arst_err got=%h exp=0", err_overrun); end
    total++; if (dsw !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL arst_dsw got=%h exp=ffffffffffffffff", dsw); end
    @(negedge clk_sys);
    reset_n = 1'b1;
    tick();
    total++; if (rom_wr !== 4'h0) begin bad++; $display("FAIL arst_nohi got=%h exp=0", rom_wr); end
    tick();
    total++; if (rom_wr !== 4'h0) begin bad++; $display("FAIL arst_nohi2 got=%h exp=0", rom_wr); end
    total++; if (ioctl_wait !== 1'b0) begin bad++; $display("FAIL arst_wait2 got=%h exp=0", ioctl_wait); end
  endtask

  initial begin
    test_reset();
    test_rom_word();
    test_back_to_back();
    test_out_of_range();
    test_load_done();
    test_fall_midword();
    test_overrun();
    test_dsw();
    test_reset_midword();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
